sdram_device_model: RTL and testbench
=====================================

Name: sdram_device_model

Overview:
- Synthesizable, cycle-accurate SDR SDRAM responder for simulation and FPGA self-test benches.
- Sits on the device side of the 32-bit SDRAM pin interface and is driven directly by the byte-based SDRAM controller.
- Decodes RAS#/CAS#/WE# commands and tracks per-bank open rows.
- Stores data with DQM byte masking, returns read data after the programmed CAS latency, and flags protocol and timing misuse.

Parameters:
- DATA_WIDTH, 32, DQ width; 4 byte lanes and 4 DQM bits.
- ROW_WIDTH, 11, row address width (SDRAM_A width).
- COL_WIDTH, 8, column bits taken from SDRAM_A[COL_WIDTH-1:0].
- BANK_WIDTH, 2, bank address width.
- MEM_AW, 10, backing array depth is 2^MEM_AW words; index is the low MEM_AW bits of {BA,row,col}, so aliasing is allowed.
- T_RCD, 2, minimum cycles from ACT to RD/WR in the same bank.
- T_RP, 2, minimum cycles from PRE to ACT in the same bank.
- T_RC, 6, minimum cycles ACT->ACT (same bank), REF->ACT and REF->REF.
- T_WR, 2, write recovery before auto-precharge starts.
- T_MRD, 2, minimum cycles from MRS to the next non-NOP command.

Ports:
- clk  in  1  SDRAM clock; all sampling on the rising edge.
- resetn  in  1  synchronous active-low reset.
- SDRAM_CKE  in  1  clock enable; 0 means the command is ignored (treated as NOP).
- SDRAM_nCS  in  1  chip select; 1 means NOP.
- SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE  in  1 each  command bits.
- SDRAM_BA  in  BANK_WIDTH  bank address.
- SDRAM_A  in  ROW_WIDTH  row/column address; A[10] = auto-precharge / precharge-all.
- SDRAM_DQM  in  4  byte masks; 1 = lane masked.
- dq_in  in  DATA_WIDTH  write data from the controller.
- dq_out  out  DATA_WIDTH  read data to the controller.
- dq_oe  out  1  1 while dq_out carries valid read data.
- err_cmd  out  1  sticky illegal-command flag.
- err_timing  out  1  sticky timing-violation flag.
- ref_count  out  16  saturating count of accepted REF commands.

Behaviour:
- Reset values: dq_out=0, dq_oe=0, err_cmd=0, err_timing=0, ref_count=0, all banks idle, CAS=3, read pipeline flushed. Array contents are not reset.
- Reset is synchronous; asserting resetn low mid-read drops the read and forces dq_oe to 0 at that edge.
- Commands are decoded on {nRAS,nCAS,nWE} when nCS=0 and CKE=1:
  - 000 MRS, 001 REF, 010 PRE, 011 ACT, 100 WR, 101 RD, 111 NOP.
  - 110 (burst stop) is treated as NOP.
- Bank state is IDLE or ACTIVE(row) per bank.
- MRS:
  - Requires all banks idle, otherwise err_cmd is set and the command is ignored.
  - CAS <= A[6:4]; only 2 or 3 are legal.
  - A[2:0] must be 000 (burst length 1) and A[3] is don't-care.
  - An illegal CAS or burst length sets err_cmd and keeps the previous CAS.
- ACT: bank must be IDLE, otherwise err_cmd. Bank goes to ACTIVE with row=A.
- WR:
  - Bank must be ACTIVE, otherwise err_cmd and no array write.
  - dq_in is captured in the command cycle.
  - Byte lane i is written only where DQM[i]=0.
  - Write and read in the same cycle to the same index: the read returns the old data.
- RD:
  - Bank must be ACTIVE, otherwise err_cmd and no data returned.
  - For a command sampled at edge N, dq_out/dq_oe are registered at edge N+CAS-1 and held one cycle, so data is valid at edge N+CAS.
  - Lanes masked by DQM at edge N return 8'h00.
  - Back-to-back reads keep dq_oe continuously 1.
- Auto-precharge (A[10]=1 on RD/WR): the bank returns to IDLE after the command. Its T_RP window starts at the RD edge, or T_WR cycles after the WR edge.
- PRE: A[10]=1 precharges all banks, otherwise bank BA only. Precharging an idle bank is a legal no-op.
- REF:
  - Requires all banks idle, otherwise err_cmd.
  - ref_count increments and saturates at 16'hFFFF.
- err_cmd and err_timing clear only on reset.
- The array is a single-port synchronous RAM, 32 bits wide with byte write enables.

Optional Feature:
- Macro SDRAM_MODEL_TIMING_CHECK_EN.
- Defined:
  - Per-bank down-counters enforce T_RCD, T_RP (plus T_WR for write auto-precharge) and T_RC.
  - A global counter enforces T_MRD, and REF->REF/ACT uses T_RC.
  - An early command sets err_timing; the command still executes.
- Undefined: no timing counters; err_timing is tied to 0.

Test Plan:
- PRE-all, REF, REF, MRS A=0x030 with legal spacing -> CAS=3, ref_count=2, err_cmd=0, err_timing=0.
- ACT bank1 row 5; 2 cycles later WR col 0x12 with A[10]=1, dq_in=0xAABBCCDD, DQM=4'b1110; after T_WR+T_RP cycles, ACT, then RD col 0x12 at edge N -> dq_oe=1 exactly at edge N+3, dq_out[7:0]=0xDD, other lanes hold their prior contents.
- MRS with A[6:4]=2 followed by a read -> data valid at edge N+2. MRS with A[6:4]=5 -> err_cmd=1 and CAS stays 2.
- RD to an idle bank -> err_cmd=1, dq_oe stays 0. ACT to an active bank -> err_cmd=1.
- With SDRAM_MODEL_TIMING_CHECK_EN: ACT then RD 1 cycle later (T_RCD=2) -> err_timing=1 and the read data is still returned. Without the macro -> err_timing=0.
- Issue RD, then pull resetn low at edge N+1 -> dq_oe=0 at edge N+1 and stays 0; all outputs at their reset values.

Source files
------------

// File: rtl/sdram_device_model_if.sv
// rtl/sdram_device_model_if.sv - SDR SDRAM pin bundle between a controller and the device model
//
// Signals:
//   SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE  command pins
//   SDRAM_BA    bank address
//   SDRAM_A     row/column address, A[10] = auto-precharge / precharge-all
//   SDRAM_DQM   per-byte masks, 1 = lane masked
//   dq_in       write data from the controller
//   dq_out      read data from the device
//   dq_oe       1 while dq_out carries read data
// Modports: master = controller side, slave = device side.
interface sdram_device_model_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ROW_WIDTH  = 11,
   parameter int BANK_WIDTH = 2
);
   logic                    SDRAM_CKE;
   logic                    SDRAM_nCS;
   logic                    SDRAM_nRAS;
   logic                    SDRAM_nCAS;
   logic                    SDRAM_nWE;
   logic [BANK_WIDTH-1:0]   SDRAM_BA;
   logic [ROW_WIDTH-1:0]    SDRAM_A;
   logic [DATA_WIDTH/8-1:0] SDRAM_DQM;
   logic [DATA_WIDTH-1:0]   dq_in;
   logic [DATA_WIDTH-1:0]   dq_out;
   logic                    dq_oe;

   modport master (
      output SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
      output SDRAM_BA, SDRAM_A, SDRAM_DQM, dq_in,
      input  dq_out, dq_oe
   );

   modport slave (
      input  SDRAM_CKE, SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE,
      input  SDRAM_BA, SDRAM_A, SDRAM_DQM, dq_in,
      output dq_out, dq_oe
   );
endinterface

// File: rtl/sdram_device_model.sv
// rtl/sdram_device_model.sv - cycle-accurate SDR SDRAM responder with protocol and timing checks
//
// Ports:
//   clk         SDRAM clock, rising edge
//   resetn      synchronous active-low reset
//   sd          sdram_device_model_if.slave pin bundle (commands, address, DQM, dq_in/dq_out/dq_oe)
//   err_cmd     sticky illegal-command flag
//   err_timing  sticky timing-violation flag
//   ref_count   saturating count of accepted REF commands
// Optional feature macro: SDRAM_MODEL_TIMING_CHECK_EN enables T_RCD/T_RP/T_WR/T_RC/T_MRD
// counters; without it err_timing is constant 0.
module sdram_device_model #(
   parameter int DATA_WIDTH = 32,
   parameter int ROW_WIDTH  = 11,
   parameter int COL_WIDTH  = 8,
   parameter int BANK_WIDTH = 2,
   parameter int MEM_AW     = 10,
   parameter int T_RCD      = 2,
   parameter int T_RP       = 2,
   parameter int T_RC       = 6,
   parameter int T_WR       = 2,
   parameter int T_MRD      = 2
) (
   input  logic                clk,
   input  logic                resetn,
   sdram_device_model_if.slave sd,
   output logic                err_cmd,
   output logic                err_timing,
   output logic [15:0]         ref_count
);
   localparam int NB    = 1 << BANK_WIDTH;
   localparam int LANES = DATA_WIDTH / 8;

   typedef enum logic [2:0] {
      C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
      C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111
   } cmd_t;

   cmd_t                  cmd;
   logic [BANK_WIDTH-1:0] ba;
   logic [ROW_WIDTH-1:0]  a;
   logic [LANES-1:0]      dqm;
   logic [NB-1:0]         bank_act;
   logic [ROW_WIDTH-1:0]  bank_row [NB];
   logic [2:0]            cas_lat;
   logic                  all_idle, cur_act;
   logic                  mrs_ok, ref_ok, act_ok, wr_ok, rd_ok, cmd_bad;
   logic [MEM_AW-1:0]     mem_idx;

   // Read pipeline: stage 1 follows the RAM read, stage 2 adds the extra cycle for CAS 3.
   logic                  p1_vld, p1_cas2, p2_vld;
   logic [LANES-1:0]      p1_mask;
   logic [DATA_WIDTH-1:0] p2_data, ram_q, ram_masked;
   logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

   always_comb begin
      ba       = sd.SDRAM_BA;
      a        = sd.SDRAM_A;
      dqm      = sd.SDRAM_DQM;
      cmd      = C_NOP;
      if (!sd.SDRAM_nCS && sd.SDRAM_CKE)
         cmd = cmd_t'({sd.SDRAM_nRAS, sd.SDRAM_nCAS, sd.SDRAM_nWE});
      all_idle = ~|bank_act;
      cur_act  = bank_act[ba];
      mrs_ok   = (cmd == C_MRS) && all_idle && (a[6:4] == 3'd2 || a[6:4] == 3'd3) && (a[2:0] == 3'b000);
      ref_ok   = (cmd == C_REF) && all_idle;
      act_ok   = (cmd == C_ACT) && !cur_act;
      wr_ok    = (cmd == C_WR) && cur_act;
      rd_ok    = (cmd == C_RD) && cur_act;
      cmd_bad  = ((cmd == C_MRS) && !mrs_ok) || ((cmd == C_REF) && !ref_ok) ||
                 ((cmd == C_ACT) && !act_ok) || ((cmd == C_WR) && !wr_ok) ||
                 ((cmd == C_RD) && !rd_ok);
      // Truncating {bank,row,col} deliberately aliases the small array onto the full address space.
      mem_idx  = MEM_AW'({ba, bank_row[ba], a[COL_WIDTH-1:0]});
   end

   // Single-port array: read-before-write, so a same-index access returns the old word.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         for (int i = 0; i < LANES; i++)
            if (!dqm[i]) mem[mem_idx][8*i +: 8] <= sd.dq_in[8*i +: 8];
      end
      if (rd_ok) ram_q <= mem[mem_idx];
   end

   always_comb begin
      ram_masked = ram_q;
      for (int i = 0; i < LANES; i++)
         if (p1_mask[i]) ram_masked[8*i +: 8] = 8'h00;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         bank_act  <= '0;
         cas_lat   <= 3'd3;
         err_cmd   <= 1'b0;
         ref_count <= 16'd0;
         p1_vld    <= 1'b0;
         p1_cas2   <= 1'b0;
         p1_mask   <= '0;
         p2_vld    <= 1'b0;
         p2_data   <= '0;
         sd.dq_out <= '0;
         sd.dq_oe  <= 1'b0;
      end else begin
         if (cmd_bad) err_cmd <= 1'b1;
         if (mrs_ok) cas_lat <= a[6:4];
         if (ref_ok && ref_count != 16'hFFFF) ref_count <= ref_count + 16'd1;
         if (act_ok) begin
            bank_act[ba] <= 1'b1;
            bank_row[ba] <= a;
         end
         if ((wr_ok || rd_ok) && a[10]) bank_act[ba] <= 1'b0;
         if (cmd == C_PRE) begin
            for (int b = 0; b < NB; b++)
               if (a[10] || BANK_WIDTH'(b) == ba) bank_act[b] <= 1'b0;
         end

         p1_vld  <= rd_ok;
         p1_cas2 <= (cas_lat == 3'd2);
         p1_mask <= dqm;
         p2_vld  <= p1_vld && !p1_cas2;
         p2_data <= ram_masked;
         if (p2_vld) begin
            sd.dq_out <= p2_data;
            sd.dq_oe  <= 1'b1;
         end else if (p1_vld && p1_cas2) begin
            sd.dq_out <= ram_masked;
            sd.dq_oe  <= 1'b1;
         end else begin
            sd.dq_oe  <= 1'b0;
         end
      end
   end

`ifdef SDRAM_MODEL_TIMING_CHECK_EN
   localparam int CW = $clog2(T_RC + T_WR + T_RP + T_RCD + T_MRD + 1);
   logic [CW-1:0] rcd_cnt [NB];
   logic [CW-1:0] rp_cnt  [NB];
   logic [CW-1:0] rc_cnt  [NB];
   logic [CW-1:0] mrd_cnt, ref_cnt;
   logic          early;

   // A counter loaded with T-1 at the command edge reaches zero exactly T edges later.
   always_comb begin
      early = 1'b0;
      if (cmd != C_NOP && cmd != C_BST && mrd_cnt != '0) early = 1'b1;
      if (act_ok && (rp_cnt[ba] != '0 || rc_cnt[ba] != '0 || ref_cnt != '0)) early = 1'b1;
      if ((wr_ok || rd_ok) && rcd_cnt[ba] != '0) early = 1'b1;
      if (ref_ok && ref_cnt != '0) early = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int b = 0; b < NB; b++) begin
            rcd_cnt[b] <= '0;
            rp_cnt[b]  <= '0;
            rc_cnt[b]  <= '0;
         end
         mrd_cnt    <= '0;
         ref_cnt    <= '0;
         err_timing <= 1'b0;
      end else begin
         if (early) err_timing <= 1'b1;
         if (mrd_cnt != '0) mrd_cnt <= mrd_cnt - CW'(1);
         if (ref_cnt != '0) ref_cnt <= ref_cnt - CW'(1);
         for (int b = 0; b < NB; b++) begin
            if (rcd_cnt[b] != '0) rcd_cnt[b] <= rcd_cnt[b] - CW'(1);
            if (rc_cnt[b] != '0)  rc_cnt[b]  <= rc_cnt[b] - CW'(1);
            if (rp_cnt[b] != '0)  rp_cnt[b]  <= rp_cnt[b] - CW'(1);
            if (cmd == C_PRE && bank_act[b] && (a[10] || BANK_WIDTH'(b) == ba))
               rp_cnt[b] <= CW'(T_RP - 1);
         end
         if (mrs_ok) mrd_cnt <= CW'(T_MRD - 1);
         if (ref_ok) ref_cnt <= CW'(T_RC - 1);
         if (act_ok) begin
            rcd_cnt[ba] <= CW'(T_RCD - 1);
            rc_cnt[ba]  <= CW'(T_RC - 1);
         end
         if (rd_ok && a[10]) rp_cnt[ba] <= CW'(T_RP - 1);
         // Write auto-precharge only begins after write recovery.
         if (wr_ok && a[10]) rp_cnt[ba] <= CW'(T_WR + T_RP - 1);
      end
   end
`else
   logic unused_timing;
   assign unused_timing = ^{T_RCD, T_RP, T_RC, T_WR, T_MRD};
   assign err_timing    = 1'b0;
`endif
endmodule

// File: tb/tb_sdram_device_model.sv
// tb/tb_sdram_device_model.sv - scoreboard bench with directed and randomized SDRAM traffic
`timescale 1ns/1ps
module tb_sdram_device_model;
`ifdef SDRAM_MODEL_TIMING_CHECK_EN
   localparam bit TCHK = 1'b1;
`else
   localparam bit TCHK = 1'b0;
`endif
   localparam logic [2:0] MRS = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011,
                          WR  = 3'b100, RD  = 3'b101;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        err_cmd, err_timing;
   logic [15:0] ref_count;

   always #5 clk = ~clk;

   sdram_device_model_if #(.DATA_WIDTH(32), .ROW_WIDTH(11), .BANK_WIDTH(2)) sd ();

   sdram_device_model dut (
      .clk        (clk),
      .resetn     (resetn),
      .sd         (sd),
      .err_cmd    (err_cmd),
      .err_timing (err_timing),
      .ref_count  (ref_count)
   );

   typedef struct {
      logic [31:0] data;
      logic [31:0] kmask;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   // Reference model: word array with per-byte "known" flags, open-bank table, CAS, REF count.
   logic [31:0] mmem   [1024];
   logic [3:0]  mknown [1024];
   bit          m_act  [4];
   int          m_row  [4];
   int          m_cas, m_refs;
   bit          exp_err;
   int          cyc = 0;
   int          n_tests = 0, n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int midx(input int b, input int r, input int c);
      return ((b << 19) | (r << 8) | c) & 1023;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pins_nop();
      sd.SDRAM_nCS = 1'b1;
      {sd.SDRAM_nRAS, sd.SDRAM_nCAS, sd.SDRAM_nWE} = 3'b111;
   endtask

   task automatic nop(input int n);
      repeat (n) begin
         @(negedge clk);
         pins_nop();
      end
   endtask

   function automatic bit m_idle();
      return !(m_act[0] || m_act[1] || m_act[2] || m_act[3]);
   endfunction

   // Drives one command for the coming edge and applies its effect to the model.
   task automatic issue(input logic [2:0] c, input int b, input int a,
                        input logic [3:0] dqm, input logic [31:0] d);
      int          idx, cs;
      logic [31:0] ed, km;
      @(negedge clk);
      sd.SDRAM_nCS = 1'b0;
      {sd.SDRAM_nRAS, sd.SDRAM_nCAS, sd.SDRAM_nWE} = c;
      sd.SDRAM_BA  = 2'(b);
      sd.SDRAM_A   = 11'(a);
      sd.SDRAM_DQM = dqm;
      sd.dq_in     = d;
      cs = (a >> 4) & 7;
      case (c)
         MRS: if (m_idle() && (cs == 2 || cs == 3) && (a & 7) == 0) m_cas = cs; else exp_err = 1'b1;
         REF: if (!m_idle()) exp_err = 1'b1; else if (m_refs < 65535) m_refs++;
         PRE: for (int i = 0; i < 4; i++) if (((a >> 10) & 1) == 1 || i == b) m_act[i] = 1'b0;
         ACT: if (m_act[b]) exp_err = 1'b1; else begin m_act[b] = 1'b1; m_row[b] = a; end
         WR: begin
            if (!m_act[b]) exp_err = 1'b1;
            else begin
               idx = midx(b, m_row[b], a & 255);
               for (int i = 0; i < 4; i++)
                  if (!dqm[i]) begin
                     mmem[idx][8*i +: 8] = d[8*i +: 8];
                     mknown[idx][i] = 1'b1;
                  end
               if (((a >> 10) & 1) == 1) m_act[b] = 1'b0;
            end
         end
         RD: begin
            if (!m_act[b]) exp_err = 1'b1;
            else begin
               idx = midx(b, m_row[b], a & 255);
               for (int i = 0; i < 4; i++) begin
                  ed[8*i +: 8] = dqm[i] ? 8'h00 : mmem[idx][8*i +: 8];
                  km[8*i +: 8] = (dqm[i] || mknown[idx][i]) ? 8'hFF : 8'h00;
               end
               // Edge N = cyc+1; data registered at N+CAS-1 and seen at the following negedge.
               sb.push_back('{data: ed, kmask: km, cyc: cyc + m_cas});
               if (((a >> 10) & 1) == 1) m_act[b] = 1'b0;
            end
         end
         default: ;
      endcase
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      pins_nop();
      for (int i = 0; i < 4; i++) m_act[i] = 1'b0;
      m_cas = 3; m_refs = 0; exp_err = 1'b0;
      sb.delete();
      @(negedge clk);
      check("rst_dq_oe", sd.dq_oe, 0);
      check("rst_dq_out", sd.dq_out, 0);
      check("rst_err_cmd", err_cmd, 0);
      check("rst_err_timing", err_timing, 0);
      check("rst_ref_count", ref_count, 0);
      @(negedge clk);
      check("rst_dq_oe_hold", sd.dq_oe, 0);
      resetn = 1'b1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL rd_missing: got no dq_oe at cycle %0d, expected data 0x%0h at cycle %0d", cyc, e.data, e.cyc);
      end
      if (sd.dq_oe === 1'b1) begin
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rd_spurious: got dq_oe=1 data 0x%0h at cycle %0d, expected dq_oe=0", sd.dq_out, cyc);
         end else begin
            e = sb.pop_front();
            check("rd_cycle", cyc, e.cyc);
            check("rd_data", sd.dq_out & e.kmask, e.data & e.kmask);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish within time limit");
      $fatal(1);
   end

   initial begin
      int b, r, c, a10;
      sd.SDRAM_CKE = 1'b1;
      sd.SDRAM_BA  = '0;
      sd.SDRAM_A   = '0;
      sd.SDRAM_DQM = '0;
      sd.dq_in     = '0;
      pins_nop();
      for (int i = 0; i < 1024; i++) begin
         mmem[i]   = '0;
         mknown[i] = '0;
      end

      // Init sequence, CAS 3 masked write / read, back-to-back reads, CAS 2, illegal MRS.
      do_reset();
      issue(PRE, 0, 1024, 4'h0, 0); nop(1);
      issue(REF, 0, 0, 4'h0, 0);    nop(5);
      issue(REF, 0, 0, 4'h0, 0);    nop(5);
      issue(MRS, 0, 'h030, 4'h0, 0); nop(1);
      check("init_ref_count", ref_count, 2);
      check("init_err_cmd", err_cmd, 0);
      check("init_err_timing", err_timing, 0);
      issue(ACT, 1, 5, 4'h0, 0); nop(1);
      issue(WR, 1, 'h012, 4'h0, 32'h11223344); nop(1);
      issue(WR, 1, 'h412, 4'b1110, 32'hAABBCCDD); nop(3);
      issue(ACT, 1, 5, 4'h0, 0); nop(1);
      issue(RD, 1, 'h012, 4'h0, 0);
      issue(RD, 1, 'h012, 4'b0101, 0); nop(1);
      issue(PRE, 1, 0, 4'h0, 0); nop(4);
      issue(MRS, 0, 'h020, 4'h0, 0); nop(1);
      issue(ACT, 2, 7, 4'h0, 0); nop(1);
      issue(WR, 2, 5, 4'h0, $urandom);
      issue(RD, 2, 5, 4'h0, 0); nop(3);
      check("cas2_err_cmd", err_cmd, exp_err);
      issue(PRE, 0, 1024, 4'h0, 0); nop(1);
      issue(MRS, 0, 'h050, 4'h0, 0); nop(1);
      check("bad_mrs_err_cmd", err_cmd, 1);
      issue(ACT, 0, 2, 4'h0, 0); nop(1);
      issue(WR, 0, 9, 4'h0, $urandom);
      issue(RD, 0, 9, 4'b1000, 0); nop(4);
      issue(PRE, 0, 1024, 4'h0, 0); nop(2);

      // Read to an idle bank.
      do_reset();
      issue(RD, 0, 0, 4'h0, 0);
      for (int i = 0; i < 5; i++) begin
         nop(1);
         check("idle_rd_dq_oe", sd.dq_oe, 0);
      end
      check("idle_rd_err_cmd", err_cmd, 1);

      // Activate an already active bank.
      do_reset();
      issue(ACT, 0, 0, 4'h0, 0); nop(5);
      check("act_ok_err_cmd", err_cmd, 0);
      issue(ACT, 0, 1, 4'h0, 0); nop(1);
      check("act_active_err_cmd", err_cmd, 1);
      check("act_active_err_timing", err_timing, 0);

      // Early read after ACT (aliases onto the word written in bank 1 row 5).
      do_reset();
      issue(ACT, 3, 1, 4'h0, 0);
      issue(RD, 3, 'h012, 4'h0, 0); nop(5);
      check("early_rd_err_timing", err_timing, TCHK);
      check("early_rd_err_cmd", err_cmd, 0);

      // Reset asserted at the edge where CAS 2 data would be registered.
      do_reset();
      issue(MRS, 0, 'h020, 4'h0, 0); nop(1);
      issue(ACT, 0, 0, 4'h0, 0); nop(1);
      issue(RD, 0, 0, 4'h0, 0);
      do_reset();

      // Randomized legal traffic, every command spaced beyond all timing limits.
      for (int k = 0; k < 160; k++) begin
         b = $urandom_range(0, 3);
         r = $urandom_range(0, 9);
         c = $urandom_range(0, 15);
         a10 = ($urandom_range(0, 3) == 0) ? 1024 : 0;
         if (m_idle() && r == 0)
            issue(MRS, 0, $urandom_range(2, 3) << 4, 4'h0, 0);
         else if (m_idle() && r == 1)
            issue(REF, 0, 0, 4'h0, 0);
         else if (!m_act[b])
            issue(ACT, b, $urandom_range(0, 3), 4'h0, 0);
         else if (r < 5)
            issue(WR, b, a10 | c, 4'($urandom_range(0, 15)), $urandom);
         else if (r < 8)
            issue(RD, b, a10 | c, 4'($urandom_range(0, 15)), 0);
         else
            issue(PRE, b, a10, 4'h0, 0);
         nop(5);
      end
      for (int w = 0; w < 20 && sb.size() > 0; w++) nop(1);
      check("sb_drain", sb.size(), 0);
      check("rand_err_cmd", err_cmd, exp_err);
      check("rand_err_timing", err_timing, 0);
      check("rand_ref_count", ref_count, m_refs);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
